// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem request feeding a 2-entry
// {inst, pc} queue toward decode, with redirect and stale-word drop.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] stale_q, stale_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] inst_mem_q [2];
  logic [31:0] inst_mem_d [2];
  logic [63:0] pc_mem_q [2];
  logic [63:0] pc_mem_d [2];

  logic       pop, push, tail;
  logic [1:0] count_nx;

  assign imem_req   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr  = (state_q == DROP) ? stale_q : fetch_pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_mem_q[head_q];
  assign inst_pc    = pc_mem_q[head_q];

  assign pop      = inst_valid & ~stall & ~redirect;
  assign push     = (state_q == REQ) & imem_ack & ~redirect;
  assign tail     = head_q ^ count_q[0];
  assign count_nx = count_q + 2'(push) - 2'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    count_d    = count_q;
    head_d     = head_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (redirect) begin
      count_d    = 2'd0;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      unique case (state_q)
        REQ: begin
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            state_d = DROP;
            stale_d = fetch_pc_q;
          end
        end
        // the stale word still completes and is dropped
        DROP: if (imem_ack) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end else begin
      count_d = count_nx;
      if (push) begin
        inst_mem_d[tail] = imem_rdata;
        pc_mem_d[tail]   = fetch_pc_q;
        fetch_pc_d       = fetch_pc_q + 64'd4;
      end
      if (pop) head_d = ~head_q;
      unique case (state_q)
        IDLE: if (count_nx < 2'd2) state_d = REQ;
        REQ: begin
          if (imem_ack)
            state_d = (count_nx < 2'd2) ? REQ : IDLE;
        end
        DROP: if (imem_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      stale_q       <= 64'h0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      inst_mem_q[0] <= 32'h0;
      inst_mem_q[1] <= 32'h0;
      pc_mem_q[0]   <= 64'h0;
      pc_mem_q[1]   <= 64'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      head_q     <= head_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 stall  input  1  SHALL mean decode cannot accept an instruction this cycle.
REQ-005 redirect  input  1  SHALL request a fetch-stream restart at redirect_pc.
REQ-006 redirect_pc  input  64  SHALL be the restart address, valid when redirect=1.
REQ-007 imem_req  output  1  SHALL be the instruction memory request strobe.
REQ-008 imem_addr  output  64  SHALL be the request address, valid when imem_req=1.
REQ-009 imem_ack  input  1  SHALL mean imem_rdata is valid and the request completes this cycle.
REQ-010 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-011 inst  output  32  SHALL be the instruction word presented to decode.
REQ-012 inst_pc  output  64  SHALL be the address of inst.
REQ-013 inst_valid  output  1  SHALL mean inst/inst_pc hold a live instruction.

Function
REQ-014 The block SHALL hold fetch_pc (64 b), a 2-entry FIFO of {inst, pc}, a 2-bit count (0..2) and a state register {IDLE, REQ, DROP}.
REQ-015 imem_req SHALL be 1 exactly in REQ and DROP; imem_addr SHALL equal fetch_pc in REQ and the held stale address in DROP, stable until imem_ack.
REQ-016 At most one memory request SHALL be outstanding; imem_ack outside REQ/DROP SHALL be ignored.
REQ-017 pop SHALL be inst_valid & !stall & !redirect; push SHALL be state==REQ & imem_ack & !redirect.
REQ-018 On push, {imem_rdata, fetch_pc} SHALL be written to the FIFO tail and fetch_pc SHALL advance by 4 (64-bit wrap-around).
REQ-019 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-020 inst_valid SHALL be (count != 0); inst/inst_pc SHALL reflect the FIFO head combinationally.
REQ-021 IDLE -> REQ SHALL occur when !redirect and count_next < 2; otherwise remain IDLE.
REQ-022 REQ with ack and no redirect SHALL go to REQ if count_next < 2 (back-to-back fetch), else IDLE.
REQ-023 REQ without ack SHALL stay REQ, holding imem_addr.
REQ-024 Redirect in any state SHALL empty the FIFO (count=0) and load fetch_pc with {redirect_pc[63:2], 2'b00}.
REQ-025 Redirect in REQ without same-cycle ack SHALL go to DROP; with same-cycle ack the word SHALL be discarded and state SHALL go to IDLE.
REQ-026 DROP SHALL hold imem_req=1 on the stale address until imem_ack, discard that word, then go to IDLE.
REQ-027 Redirect in IDLE or DROP SHALL not change the state, only fetch_pc and FIFO.
REQ-028 Redirect SHALL take priority over pop and push in the same cycle.
REQ-029 Latency: with imem_ack in the issue cycle, inst_valid SHALL rise one cycle after imem_req first rises; steady-state throughput SHALL be one instruction per cycle when stall=0 and ack is immediate.
REQ-030 A full FIFO with stall=1 SHALL hold all outputs and issue no requests.

Reset
REQ-031 While reset=1: state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, inst_valid=0, inst=32'h0, inst_pc=64'h0.
REQ-032 Reset asserted mid-request SHALL abandon the request immediately; a later imem_ack SHALL be ignored.
REQ-033 After reset deasserts, imem_req SHALL rise at the first rising edge with imem_addr=RESET_PC.

Verification
REQ-034 Reset release, imem_ack tied 1, stall=0 -> imem_addr 0x0,0x4,0x8... each cycle; inst_pc follows one cycle behind with the matching words.
REQ-035 stall=1 for 5 cycles, ack immediate -> exactly 2 instructions buffered, imem_req drops to 0, inst_pc holds 0x0; on stall release, 0x0,0x4,0x8 emerge in order with no gap or loss.
REQ-036 Ack delayed 3 cycles -> imem_addr stable for 4 cycles, inst_valid rises the cycle after ack.
REQ-037 Redirect to 0x1002 while a request for 0x8 awaits ack -> DROP; the 0x8 word is discarded, the next request is 0x1000, inst_valid=0 until that word returns.
REQ-038 Redirect with ack and pop in the same cycle, count=2 -> count=0, word discarded, next fetch at the redirect address.
REQ-039 Assert reset while in REQ with count=1 -> all outputs reach reset values asynchronously; next fetch after release at RESET_PC.
